userhw_in_capture: RTL and testbench
====================================

# userhw_in_capture

Input-conditioning stage that drives the 17-bit `in_port` of the system's read-only PIO slave. It synchronises and debounces 16 raw board inputs (switches/keys) and holds a snapshot of the debounced word whenever it changes. A pending-change flag on bit 16 tells software a new value is waiting. Software clears the flag by toggling an acknowledge line driven from a PIO output.

## Interface
- `WIDTH`, 16: raw input width; output is `WIDTH+1` bits.
- `TICK_DIV`, 50000: clock cycles per debounce sample tick (1 ms at 50 MHz); minimum 2.
- `STABLE_SAMPLES`, 4: consecutive equal tick samples required to accept a new bit value; range 2..8.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `raw_in`  in  WIDTH: asynchronous board inputs.
- `ack_toggle`  in  1: level from a PIO output register, synchronous to `clk`; every edge acknowledges one event.
- `pio_in`  out  WIDTH+1: `[WIDTH]` = change pending, `[WIDTH-1:0]` = captured debounced word.
- `overrun`  out  1: sticky; set when the debounced word changed while the flag was already pending.

## Operation
- Synchroniser: two flops per bit of `raw_in`, producing `sync_in`.
- Tick counter: counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when the count equals TICK_DIV-1.
- Debounce, per bit: a shift history of STABLE_SAMPLES entries samples `sync_in` on `tick`. When the history holds all 1s or all 0s and that value differs from `deb[i]`, `deb[i]` takes that value on the same `tick` edge.
- Change detect: `deb_chg = (deb != deb_d)`, where `deb_d` is `deb` delayed one cycle.
- Ack detect: `ack_evt = ack_toggle ^ ack_d`, where `ack_d` is registered.
- Capture register `snap[WIDTH-1:0]` and flag `pend`, evaluated each cycle in this priority order:
  - `deb_chg` and (`pend == 0` or `ack_evt`): `snap <= deb`, `pend <= 1`.
  - `deb_chg` and `pend == 1` and no `ack_evt`: `snap <= deb` (the newest value always wins), `overrun <= 1`, `pend` stays 1.
  - `ack_evt` alone: `pend <= 0`; `snap` holds.
- A simultaneous ack and change is therefore never lost: the flag remains set and carries the new value.
- `overrun` clears only on `reset`.
- `pio_in = {pend, snap}` is a direct register output with no combinational path from inputs.
- `deb` resets to 0. If inputs are already high at reset release, a change event is raised once they pass debounce. This is intended, so software sees the power-up state.

## Timing
- Reset values: `pio_in = 0`, `overrun = 0`. Tick counter, histories, `deb`, `deb_d`, `snap` and `pend` are all 0. `ack_d` = 0.
- After reset release, the first `ack_toggle` high level counts as one ack event. Software must start at 0.
- Latency from a `raw_in` edge to `pio_in` update:
  - 2 cycles of synchronisation.
  - Up to STABLE_SAMPLES ticks of debounce; the worst case adds one partial tick period.
  - 1 cycle from `deb` to `snap`/`pend`.
- Ack latency: `pend` falls 1 cycle after the `ack_toggle` edge is registered, i.e. on the clock edge after `ack_toggle` changes.
- Glitches shorter than `(STABLE_SAMPLES-1)*TICK_DIV` cycles are rejected. Bits bouncing across a tick are not accepted until the history is uniform.
- Reset mid-debounce or while pending discards all state. No event is generated from pre-reset activity.

## Configuration
- `USERHW_IN_CAPTURE_DEBOUNCE_EN` defined:
  - Tick counter and histories are built as described above.
- Not defined:
  - Tick counter and histories are omitted.
  - `deb <= sync_in` every cycle.
  - Raw-to-`pio_in` latency is a fixed 3 cycles after the synchroniser's input flop.
  - Parameters `TICK_DIV` and `STABLE_SAMPLES` are ignored.

## Test plan
Parameters for all scenarios: TICK_DIV=4, STABLE_SAMPLES=3, DEBOUNCE_EN defined unless stated.
- Hold reset, then release with `raw_in=0` held for 100 cycles -> `pio_in=0x00000`, `overrun=0` throughout.
- Step `raw_in` to 0x00A5 and hold -> `pio_in=0x100A5` no later than 2+3*4+4+1 cycles after the step; toggle `ack_toggle` -> `pio_in=0x000A5` on the next edge.
- 5-cycle pulse of `raw_in[0]` (shorter than 8 cycles) -> `pio_in` unchanged and `pend` stays 0.
- Without ack, change 0x0001 then 0x0003 after each debounces -> `pio_in=0x10003`, `overrun=1`; after ack -> `pio_in=0x00003`, `overrun` still 1.
- Force `deb_chg` and `ack_evt` in the same cycle (`raw_in` to 0x0F0F timed with the toggle) -> `pio_in=0x10F0F`, `overrun` stays 0.
- Build without `USERHW_IN_CAPTURE_DEBOUNCE_EN`; step `raw_in` to 0xFFFF -> `pio_in=0x1FFFF` exactly 3 cycles after the first sampling edge.

Source files
------------

// File: rtl/userhw_in_capture.sv
// rtl/userhw_in_capture.sv - synchronise, debounce and snapshot board inputs for a read-only PIO slave
//
// Purpose: conditions WIDTH raw board inputs and presents a held snapshot of the
// debounced word plus a change-pending flag to software through pio_in.
// Software clears the flag by toggling ack_toggle from a PIO output register.
//
// Optional feature macro: USERHW_IN_CAPTURE_DEBOUNCE_EN
//   defined     : tick counter and per-bit sample histories debounce sync_in
//   not defined : deb follows sync_in every cycle; TICK_DIV/STABLE_SAMPLES unused
//
// Ports:
//   clk         in   1        system clock
//   reset       in   1        asynchronous active-high reset
//   raw_in      in   WIDTH    asynchronous board inputs
//   ack_toggle  in   1        acknowledge level, each edge acknowledges one event
//   pio_in      out  WIDTH+1  {change pending, captured debounced word}
//   overrun     out  1        sticky: word changed while an event was still pending

module userhw_in_capture #(
    parameter int WIDTH          = 16,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             ack_toggle,
    output logic [WIDTH:0]   pio_in,
    output logic             overrun
);

    // Reject out-of-range configurations at elaboration.
    if (TICK_DIV < 2 || STABLE_SAMPLES < 2 || STABLE_SAMPLES > 8) begin : g_bad_params
        $error("userhw_in_capture: TICK_DIV must be >= 2 and STABLE_SAMPLES in 2..8");
    end

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] snap;
    logic             pend;
    logic             ack_d;
    logic             deb_chg;
    logic             ack_evt;

    // Two-flop synchroniser per bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta    <= '0;
            sync_in <= '0;
        end else begin
            meta    <= raw_in;
            sync_in <= meta;
        end
    end

`ifdef USERHW_IN_CAPTURE_DEBOUNCE_EN
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [STABLE_SAMPLES-1:0] hist;
        logic [STABLE_SAMPLES-1:0] hist_nxt;
        logic                      deb_bit;

        // The uniformity test looks at the history including this tick's
        // sample, so a clean edge is accepted after exactly STABLE_SAMPLES ticks.
        assign hist_nxt = {hist[STABLE_SAMPLES-2:0], sync_in[i]};
        assign deb[i]   = deb_bit;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hist    <= '0;
                deb_bit <= 1'b0;
            end else if (tick) begin
                hist <= hist_nxt;
                if (&hist_nxt) begin
                    deb_bit <= 1'b1;
                end else if (~|hist_nxt) begin
                    deb_bit <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= '0;
        end else begin
            deb <= sync_in;
        end
    end
`endif

    assign deb_chg = (deb != deb_d);
    assign ack_evt = ack_toggle ^ ack_d;

    // Capture: a change always loads the newest word and (re)asserts pend.
    // A change that coincides with an ack is the new event, not an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_d   <= '0;
            ack_d   <= 1'b0;
            snap    <= '0;
            pend    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            deb_d <= deb;
            ack_d <= ack_toggle;
            if (deb_chg) begin
                snap <= deb;
                pend <= 1'b1;
                if (pend && !ack_evt) begin
                    overrun <= 1'b1;
                end
            end else if (ack_evt) begin
                pend <= 1'b0;
            end
        end
    end

    assign pio_in = {pend, snap};

endmodule

// File: tb/tb_userhw_in_capture.sv
// tb/tb_userhw_in_capture.sv - self-checking bench for userhw_in_capture

module tb_userhw_in_capture;

    localparam int W  = 16;
    localparam int TD = 4;
    localparam int SS = 3;
    localparam int STEP_BUDGET = 2 + SS * TD + TD + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic         ack_toggle = 1'b0;
    logic [W:0]   pio_in;
    logic         overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [W:0] sb[$];

    userhw_in_capture #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .STABLE_SAMPLES(SS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .ack_toggle(ack_toggle),
        .pio_in(pio_in),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Edges since reset release; matches the DUT tick counter modulo TD.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Edge on which deb takes a step applied in the cycle after edge k0.
    function automatic int deb_edge(input int k0);
        int f;
`ifdef USERHW_IN_CAPTURE_DEBOUNCE_EN
        f = k0 + 3;
        while (f % TD != 0) f++;
        return f + (SS - 1) * TD;
`else
        f = k0 + 3;
        return f;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        raw_in = '0;
        ack_toggle = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_pend(input int budget);
        for (int i = 0; i < budget && !pio_in[W]; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W:0] exp;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (pio_in !== 17'h00000 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: pio_in=%h overrun=%b want 00000/0", pio_in, overrun);
        end
        do_reset();
        for (int i = 0; i < 100; i++) begin
            sb.push_back(17'h00000);
            @(negedge clk);
            exp = sb.pop_front();
            vectors++;
            if (pio_in !== exp || overrun !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: pio_in=%h overrun=%b want %h/0", i, pio_in, overrun, exp);
            end
        end
    endtask

    task automatic test_step_ack();
        logic [W:0] exp;
        do_reset();
        @(negedge clk);
        raw_in = 16'h00A5;
        sb.push_back(17'h100A5);
        wait_pend(STEP_BUDGET);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL step_capture: pio_in=%h overrun=%b want %h/0", pio_in, overrun, exp);
        end
        ack_toggle = ~ack_toggle;
        sb.push_back(17'h000A5);
        @(negedge clk);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp) begin
            miscompares++;
            $display("FAIL step_ack: pio_in=%h want %h", pio_in, exp);
        end
    endtask

    task automatic test_glitch();
        logic [W:0] exp;
        logic       exp_ovr;
        logic       exp_seen;
        logic       seen;
        do_reset();
        repeat (7) @(negedge clk);
`ifdef USERHW_IN_CAPTURE_DEBOUNCE_EN
        exp = 17'h00000; exp_ovr = 1'b0; exp_seen = 1'b0;
`else
        exp = 17'h10000; exp_ovr = 1'b1; exp_seen = 1'b1;
`endif
        sb.push_back(exp);
        seen = 1'b0;
        raw_in = 16'h0001;
        repeat (5) begin
            @(negedge clk);
            seen |= pio_in[W];
        end
        raw_in = 16'h0000;
        repeat (30) begin
            @(negedge clk);
            seen |= pio_in[W];
        end
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== exp_ovr) begin
            miscompares++;
            $display("FAIL glitch_word: pio_in=%h overrun=%b want %h/%b", pio_in, overrun, exp, exp_ovr);
        end
        vectors++;
        if (seen !== exp_seen) begin
            miscompares++;
            $display("FAIL glitch_pend: pend seen=%b want %b", seen, exp_seen);
        end
    endtask

    task automatic test_overrun();
        logic [W:0] exp;
        do_reset();
        @(negedge clk);
        raw_in = 16'h0001;
        sb.push_back(17'h10001);
        wait_pend(STEP_BUDGET);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_first: pio_in=%h overrun=%b want %h/0", pio_in, overrun, exp);
        end
        raw_in = 16'h0003;
        sb.push_back(17'h10003);
        for (int i = 0; i < STEP_BUDGET && !pio_in[1]; i++) @(negedge clk);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_second: pio_in=%h overrun=%b want %h/1", pio_in, overrun, exp);
        end
        ack_toggle = ~ack_toggle;
        sb.push_back(17'h00003);
        @(negedge clk);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_ack: pio_in=%h overrun=%b want %h/1", pio_in, overrun, exp);
        end
    endtask

    task automatic test_simultaneous();
        logic [W:0] exp;
        int k0;
        int e;
        do_reset();
        @(negedge clk);
        raw_in = 16'h0001;
        sb.push_back(17'h10001);
        wait_pend(STEP_BUDGET);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp) begin
            miscompares++;
            $display("FAIL simul_setup: pio_in=%h want %h", pio_in, exp);
        end
        repeat (2) @(negedge clk);
        k0 = cyc;
        raw_in = 16'h0F0F;
        e = deb_edge(k0);
        for (int i = 0; i < 40 && cyc < e; i++) @(negedge clk);
        // deb has just changed; toggle so ack_evt lands in the same cycle.
        ack_toggle = ~ack_toggle;
        sb.push_back(17'h10F0F);
        @(negedge clk);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_capture: pio_in=%h overrun=%b want %h/0", pio_in, overrun, exp);
        end
        ack_toggle = ~ack_toggle;
        sb.push_back(17'h00F0F);
        @(negedge clk);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_ack: pio_in=%h overrun=%b want %h/0", pio_in, overrun, exp);
        end
    endtask

    task automatic test_all_ones_latency();
        logic [W:0] exp;
        do_reset();
        @(negedge clk);
        raw_in = 16'hFFFF;
`ifdef USERHW_IN_CAPTURE_DEBOUNCE_EN
        sb.push_back(17'h1FFFF);
        wait_pend(STEP_BUDGET);
`else
        sb.push_back(17'h00000);
        repeat (3) @(negedge clk);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp) begin
            miscompares++;
            $display("FAIL ones_early: pio_in=%h want %h", pio_in, exp);
        end
        sb.push_back(17'h1FFFF);
        @(negedge clk);
`endif
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp) begin
            miscompares++;
            $display("FAIL ones_capture: pio_in=%h want %h", pio_in, exp);
        end
    endtask

    task automatic test_reset_pending();
        logic [W:0] exp;
        do_reset();
        @(negedge clk);
        raw_in = 16'h00A5;
        wait_pend(STEP_BUDGET);
        do_reset();
        sb.push_back(17'h00000);
        repeat (30) @(negedge clk);
        exp = sb.pop_front();
        vectors++;
        if (pio_in !== exp || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pending: pio_in=%h overrun=%b want %h/0", pio_in, overrun, exp);
        end
    endtask

    initial begin
        test_reset();
        test_step_ack();
        test_glitch();
        test_overrun();
        test_simultaneous();
        test_all_ones_latency();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
